prio_ingress_arbiter: RTL and testbench
=======================================

# prio_ingress_arbiter

Arbitrates N independent writers onto the single valid/ready input channel of the priority FIFO (`fifo_priority`, DW=33, bit DW-1 = priority). Bit DW-1 of each request word selects the class: high requests win over low ones, and round-robin applies within each class. An optional aging guard bounds how long low-class requests can be starved. The output channel is registered and connects directly to the FIFO's `data_in`/`vld_i`/`rdy_o`.

## Interface
- `N`, 4, number of requesters (2..8).
- `DW`, 33, word width; bit DW-1 is the priority flag (1 = high).
- `STARVE_MAX`, 8, consecutive high grants allowed while a low request waits (guard only, ≥1).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_data_i`  in  N×DW  per-requester word.
- `req_vld_i`  in  N  per-requester valid.
- `req_rdy_o`  out  N  per-requester ready (one-hot or zero).
- `data_out`  out  DW  registered word to the FIFO `data_in`.
- `vld_o`  out  1  registered valid to the FIFO `vld_i`.
- `rdy_i`  in  1  FIFO `rdy_o`.
- `grant_o`  out  N  registered one-hot: requester whose word is in `data_out`.

## Operation
- FSM states: IDLE (output register empty) and HOLD (output register full).
- Load enable `ld = (state==IDLE) | (state==HOLD & rdy_i)`.
- When `ld` is high and any `req_vld_i` is set, the winner is chosen and its word is captured. `req_rdy_o[winner]=1` in that same cycle, and the next state is HOLD.
- When `ld` is high and no request is valid: HOLD→IDLE if rdy_i, and IDLE stays in IDLE.
- HOLD with `!rdy_i`: `data_out`, `grant_o` and `vld_o` are held stable, and all `req_rdy_o` are 0.
- Class select: high if any valid request has bit DW-1 = 1, otherwise low. The guard can override this choice.
- Within a class, round-robin starts at that class's pointer (`hp_ptr` or `lp_ptr`). Only the winning class's pointer updates, to (winner+1) mod N.
- `req_rdy_o` is combinational from `req_vld_i`/`rdy_i`. Requesters must not make `vld` depend on `rdy`.
- A requester holds its word and valid asserted until it sees `req_rdy_o`.

## Timing
- Reset values: state IDLE, `vld_o=0`, `data_out=0`, `grant_o=0`, `hp_ptr=lp_ptr=0`, starve counter 0. `req_rdy_o=0` while `rst_n=0`.
- Latency: the word is accepted at edge t (`req_vld & req_rdy`) and appears with `vld_o=1` after edge t, until the FIFO takes it.
- Throughput: one word per cycle while `rdy_i` stays high (back-to-back load in HOLD).
- FIFO full (`rdy_i=0`): there is no loss and no reordering; the held word remains in place.
- Simultaneous FIFO take and no new request: `vld_o` drops in the following cycle.
- Reset asserted mid-transfer: the held word is discarded and pointers return to 0. No `vld_o` glitch, because the output is a register with an async clear.
- Single requester: it gets `req_rdy_o` every `ld` cycle. Pointers never select an invalid requester.

## Configuration
- `PRIO_ARB_STARVE_GUARD_EN` defined: the starve counter increments on each high grant made while any low request is valid. It clears on a low grant, or on a cycle with `ld` and no low request valid.
- When the counter equals `STARVE_MAX`, the next `ld` forces the low class and the counter clears.
- Macro undefined: strict priority, no counter logic, and low requests can starve indefinitely.

## Structure
- Package `prio_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_HOLD`);
  - the `PRIO_BIT` index function/constant (DW-1);
  - the default `N`/`STARVE_MAX` values.
- Sub-module `rr_pick` (parameter N) takes a request vector and a pointer and returns a one-hot grant and a valid flag. It is instantiated twice, once per class.
- The top level holds the FSM, the output register, the class select and the starve counter.

## Test plan
- Reset, then req0 valid with 0x0_0000_00AA while the FIFO is ready. Required: `req_rdy_o=0001` in the same cycle, and next cycle `vld_o=1`, `data_out=0x0_0000_00AA`, `grant_o=0001`.
- req1 low 0x0_0000_0011 and req2 high 0x1_0000_0022 asserted together. Required: req2 is granted first and req1 in the following cycle; `data_out` sequence is 0x1_0000_0022, then 0x0_0000_0011.
- All four requesters valid with low words and `rdy_i=1` for 8 cycles. Required grant order 0,1,2,3,0,1,2,3 with one word per cycle.
- `rdy_i=0` for 5 cycles with req3 holding 0x1_DEAD_BEEF. Required: `data_out`/`vld_o` stable and all `req_rdy_o=0`; the word transfers on the first cycle `rdy_i=1`.
- Guard on, STARVE_MAX=8: req0 continuously high and req1 continuously low. Required: req1 granted after exactly 8 req0 grants, then 8 more before the next req1 grant. Guard off: req1 is never granted over 100 cycles.
- `rst_n` pulled low while in HOLD. Required: `vld_o=0` and `grant_o=0` immediately, with no transfer counted.

Source files
------------

// File: rtl/prio_arb_pkg.sv
// Shared types and defaults for the priority ingress arbiter.
// The class flag lives in the top bit of every request word.
package prio_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE,
    ARB_HOLD
  } arb_state_e;

  localparam int unsigned DefaultN         = 4;
  localparam int unsigned DefaultStarveMax = 8;

  function automatic int unsigned PRIO_BIT(int unsigned dw);
    return dw - 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Returns a one-hot grant and a flag that some request was set.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          vld
);

  always_comb begin
    int unsigned idx;
    logic        found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    vld = found;
  end

endmodule

// File: rtl/prio_ingress_arbiter.sv
// Two-class round-robin arbiter feeding a registered valid/ready output channel.
// Define PRIO_ARB_STARVE_GUARD_EN to bound how long low-class requests can be starved.
module prio_ingress_arbiter
  import prio_arb_pkg::*;
#(
  parameter int unsigned N          = DefaultN,
  parameter int unsigned DW         = 33,
  parameter int unsigned STARVE_MAX = DefaultStarveMax
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*DW-1:0] req_data_i,
  input  logic [N-1:0]    req_vld_i,
  output logic [N-1:0]    req_rdy_o,
  output logic [DW-1:0]   data_out,
  output logic            vld_o,
  input  logic            rdy_i,
  output logic [N-1:0]    grant_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PB = PRIO_BIT(DW);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] hp_ptr_q, lp_ptr_q, nxt_ptr, win_idx;
  logic [N-1:0]  hi_req, lo_req, hi_gnt, lo_gnt, win, grant_q;
  logic [DW-1:0] win_data, data_q;
  logic          hi_any, lo_any, use_hi, force_lo, ld, take;

  always_comb begin
    hi_req = '0;
    lo_req = '0;
    for (int i = 0; i < N; i++) begin
      hi_req[i] = req_vld_i[i] & req_data_i[i*DW+PB];
      lo_req[i] = req_vld_i[i] & ~req_data_i[i*DW+PB];
    end
  end

  rr_pick #(.N(N)) u_hi_pick (
    .req (hi_req),
    .ptr (hp_ptr_q),
    .gnt (hi_gnt),
    .vld (hi_any)
  );

  rr_pick #(.N(N)) u_lo_pick (
    .req (lo_req),
    .ptr (lp_ptr_q),
    .gnt (lo_gnt),
    .vld (lo_any)
  );

  assign ld     = (state_q == ARB_IDLE) | ((state_q == ARB_HOLD) & rdy_i);
  assign use_hi = hi_any & ~force_lo;
  assign win    = use_hi ? hi_gnt : lo_gnt;
  // Gating with rst_n keeps req_rdy_o low for the whole reset interval.
  assign take   = ld & (hi_any | lo_any) & rst_n;

  always_comb begin
    win_idx  = '0;
    win_data = '0;
    for (int i = 0; i < N; i++) begin
      if (win[i]) begin
        win_idx  = PW'(i);
        win_data = req_data_i[i*DW +: DW];
      end
    end
  end

  assign nxt_ptr = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;

`ifdef PRIO_ARB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve_q;

  assign force_lo = (starve_q == SW'(STARVE_MAX)) & lo_any;

  // Counts high grants made while a low request waits; any low grant resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (ld) begin
      if (!lo_any || (take && !use_hi)) begin
        starve_q <= '0;
      end else if (take && use_hi) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end
`else
  logic unused_starve_max;
  assign force_lo          = 1'b0;
  assign unused_starve_max = ^STARVE_MAX;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (take) state_d = ARB_HOLD;
      ARB_HOLD: if (rdy_i) state_d = take ? ARB_HOLD : ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_rdy_o = take ? win : '0;
    vld_o     = (state_q == ARB_HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      grant_q  <= '0;
      hp_ptr_q <= '0;
      lp_ptr_q <= '0;
    end else if (take) begin
      data_q  <= win_data;
      grant_q <= win;
      if (use_hi) begin
        hp_ptr_q <= nxt_ptr;
      end else begin
        lp_ptr_q <= nxt_ptr;
      end
    end
  end

  assign data_out = data_q;
  assign grant_o  = grant_q;

endmodule

// File: tb/tb_prio_ingress_arbiter.sv
// Randomised and directed bench for prio_ingress_arbiter with a queue-based scoreboard.
// Expected words come from a class/round-robin reference model over per-requester queues.
module tb_prio_ingress_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 33;
  localparam int unsigned SM = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N*DW-1:0] req_data_i = '0;
  logic [N-1:0]    req_vld_i = '0;
  logic [N-1:0]    req_rdy_o;
  logic [DW-1:0]   data_out;
  logic            vld_o;
  logic            rdy_i = 1'b0;
  logic [N-1:0]    grant_o;

  always #5 clk = ~clk;

  prio_ingress_arbiter #(.N(N), .DW(DW), .STARVE_MAX(SM)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_data_i (req_data_i),
    .req_vld_i  (req_vld_i),
    .req_rdy_o  (req_rdy_o),
    .data_out   (data_out),
    .vld_o      (vld_o),
    .rdy_i      (rdy_i),
    .grant_o    (grant_o)
  );

  typedef struct packed {
    logic [DW-1:0] word;
    logic [N-1:0]  gnt;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] rq[N][$];
  int            gl[$];
  int unsigned   checks = 0, passed = 0, xfers = 0;
  bit            m_hold = 0;
  int unsigned   m_hp = 0, m_lp = 0;
`ifdef PRIO_ARB_STARVE_GUARD_EN
  int unsigned   m_starve = 0;
`endif

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(logic [N-1:0] r, int unsigned p);
    for (int unsigned k = 0; k < N; k++) if (r[(p + k) % N]) return int'((p + k) % N);
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_vld_i[i] = (rq[i].size() != 0);
      if (rq[i].size() != 0) req_data_i[i*DW +: DW] = rq[i][0];
      else req_data_i[i*DW +: DW] = '0;
    end
  endtask

  // One clock cycle: predict the grant, check req_rdy_o, queue the expected output word.
  task automatic step();
    logic [N-1:0] hi, lo, exp_rdy;
    bit ld, use_hi;
    int w;
    exp_t e;
    drive();
    @(negedge clk);
    hi = '0;
    lo = '0;
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() != 0) begin
        if (rq[i][0][DW-1]) hi[i] = 1'b1;
        else lo[i] = 1'b1;
      end
    end
    ld = !m_hold || rdy_i;
    w = -1;
    use_hi = 0;
    if (ld && (hi | lo) != 0) begin
      use_hi = (hi != 0);
`ifdef PRIO_ARB_STARVE_GUARD_EN
      if (m_starve == SM && lo != 0) use_hi = 0;
`endif
      w = use_hi ? pick(hi, m_hp) : pick(lo, m_lp);
    end
`ifdef PRIO_ARB_STARVE_GUARD_EN
    if (ld) begin
      if (lo == 0 || (w >= 0 && !use_hi)) m_starve = 0;
      else if (w >= 0) m_starve++;
    end
`endif
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_rdy_o", req_rdy_o, exp_rdy);
    if (w >= 0) begin
      e.word = rq[w][0];
      e.gnt  = exp_rdy;
      sb.push_back(e);
      gl.push_back(w);
      if (use_hi) m_hp = (w + 1) % N;
      else m_lp = (w + 1) % N;
      m_hold = 1;
    end else if (ld) begin
      m_hold = 0;
    end
    @(posedge clk);
    #1;
    if (w >= 0) void'(rq[w].pop_front());
  endtask

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < N; i++) rq[i].delete();
    m_hold = 0;
    m_hp = 0;
    m_lp = 0;
`ifdef PRIO_ARB_STARVE_GUARD_EN
    m_starve = 0;
`endif
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_vld_o", vld_o, 0);
    chk("rst_grant_o", grant_o, 0);
    chk("rst_req_rdy_o", req_rdy_o, 0);
    model_reset();
    drive();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: every accepted output word is compared against the scoreboard head.
  logic [DW-1:0] prev_data;
  logic [N-1:0]  prev_gnt;
  bit            prev_stall = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("stall_vld_o", vld_o, 1);
        chk("stall_data_out", data_out, prev_data);
        chk("stall_grant_o", grant_o, prev_gnt);
      end
      if (vld_o && rdy_i) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("data_out", data_out, e.word);
          chk("grant_o", grant_o, e.gnt);
          xfers++;
        end
      end
      prev_stall = vld_o && !rdy_i;
      prev_data  = data_out;
      prev_gnt   = grant_o;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned x0, ones;
    #1 rst_n = 1'b0;
    rq[0].push_back(33'h0_0000_0077);
    drive();
    #2;
    chk("reset_vld_o", vld_o, 0);
    chk("reset_data_out", data_out, 0);
    chk("reset_grant_o", grant_o, 0);
    chk("reset_req_rdy_o", req_rdy_o, 0);
    model_reset();
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single word through an idle arbiter.
    rdy_i = 1'b1;
    rq[0].push_back(33'h0_0000_00AA);
    step();
    chk("t1_vld_o", vld_o, 1);
    chk("t1_data_out", data_out, 33'h0_0000_00AA);
    chk("t1_grant_o", grant_o, 4'b0001);
    step();

    // High class beats low class.
    rq[1].push_back(33'h0_0000_0011);
    rq[2].push_back(33'h1_0000_0022);
    step();
    chk("t2_first", data_out, 33'h1_0000_0022);
    step();
    chk("t2_second", data_out, 33'h0_0000_0011);
    step();
    step();

    // Reset while a word is held.
    rq[0].push_back(33'h1_0000_0099);
    step();
    chk("t6_hold_before_rst", vld_o, 1);
    rq[2].push_back(33'h0_0000_0044);
    drive();
    x0 = xfers;
    pulse_reset();
    step();
    chk("t6_no_xfer", xfers, x0);

    // Low-class round robin, one word per cycle.
    gl.delete();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < N; i++) rq[i].push_back(DW'(32'h100 + i * 16 + j));
    repeat (8) step();
    chk("t3_grant_count", gl.size(), 8);
    for (int k = 0; k < 8; k++) chk("t3_order", gl[k], k % 4);
    step();
    step();

    // Output stall with a pending second word.
    rq[3].push_back(33'h1_DEAD_BEEF);
    rq[3].push_back(33'h0_0000_0033);
    rdy_i = 1'b0;
    repeat (6) step();
    chk("t4_held_data", data_out, 33'h1_DEAD_BEEF);
    chk("t4_held_vld", vld_o, 1);
    rdy_i = 1'b1;
    step();
    chk("t4_next_data", data_out, 33'h0_0000_0033);
    step();

    // Starvation behaviour.
    pulse_reset();
    gl.delete();
`ifdef PRIO_ARB_STARVE_GUARD_EN
    for (int c = 0; c < 20; c++) begin
`else
    for (int c = 0; c < 100; c++) begin
`endif
      if (rq[0].size() < 2) rq[0].push_back(DW'({1'b1, 32'(c)}));
      if (rq[1].size() == 0) rq[1].push_back(DW'({1'b0, 32'h5000 + 32'(c)}));
      step();
    end
    ones = 0;
    foreach (gl[k]) if (gl[k] == 1) ones++;
`ifdef PRIO_ARB_STARVE_GUARD_EN
    chk("t5_first_low", gl[8], 1);
    chk("t5_second_low", gl[17], 1);
    chk("t5_low_count", ones, 2);
`else
    chk("t5_low_starved", ones, 0);
`endif
    rq[0].delete();
    step();
    step();
    step();

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      rdy_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (rq[i].size() < 3 && $urandom_range(0, 2) == 0)
          rq[i].push_back({1'($urandom_range(0, 1)), 32'($urandom)});
      step();
    end

    // Drain.
    rdy_i = 1'b1;
    for (int c = 0; c < 60; c++) begin
      int unsigned pend;
      pend = sb.size();
      for (int i = 0; i < N; i++) pend += rq[i].size();
      if (pend == 0) break;
      step();
    end
    chk("drain_sb", sb.size(), 0);
    chk("drain_vld_o", vld_o, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
